// File: rtl/draw_pkg.sv
// Shared drawing types.
//   rect_mode_t : rectangle style selector (RECT_FILL = solid, RECT_OUTLINE = border only)
package draw_pkg;

  typedef enum logic {
    RECT_FILL    = 1'b0,
    RECT_OUTLINE = 1'b1
  } rect_mode_t;

endpackage

// File: rtl/draw_rectangle_gen.sv
// Rectangle pixel generator: emits the pixels of a filled or outlined
// axis-aligned rectangle in raster order, one per cycle while oe is high.
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start               : begin a rectangle (sampled only in IDLE)
//   oe                  : output enable; low stalls the scan
//   mode                : RECT_FILL / RECT_OUTLINE, sampled with start
//   x0, y0, x1, y1      : opposite corners in any order, sampled with start
//   x, y                : current pixel, valid while drawing is high
//   drawing             : (x, y) is a pixel this cycle
//   busy                : not idle
//   done                : one-cycle pulse after the last pixel
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; corners and mode are latched on start
// INIT  | load scan position with the top-left corner
// DRAW  | emit one pixel per cycle in which oe is high
module draw_rectangle_gen
  import draw_pkg::*;
#(
  parameter int CORDW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             oe,
  input  rect_mode_t       mode,
  input  logic [CORDW-1:0] x0,
  input  logic [CORDW-1:0] y0,
  input  logic [CORDW-1:0] x1,
  input  logic [CORDW-1:0] y1,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic             drawing,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DRAW = 2'd2
  } state_t;

  state_t           state;
  logic [CORDW-1:0] xl, xr, yt, yb;
  rect_mode_t       mode_r;
  logic             inner_row;

  assign drawing   = (state == DRAW) && oe;
  assign busy      = (state != IDLE);
  // Rows strictly between top and bottom only contribute their two edge pixels in outline mode.
  assign inner_row = (y != yt) && (y != yb);

  // Every step compares against the bounds before incrementing, so a
  // coordinate sitting at the maximum value is never incremented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      done   <= 1'b0;
      xl     <= '0;
      xr     <= '0;
      yt     <= '0;
      yb     <= '0;
      mode_r <= RECT_FILL;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            xl     <= (x0 < x1) ? x0 : x1;
            xr     <= (x0 < x1) ? x1 : x0;
            yt     <= (y0 < y1) ? y0 : y1;
            yb     <= (y0 < y1) ? y1 : y0;
            mode_r <= mode;
            state  <= INIT;
          end
        end
        INIT: begin
          x     <= xl;
          y     <= yt;
          state <= DRAW;
        end
        DRAW: begin
          if (oe) begin
            if (x == xr && y == yb) begin
              state <= IDLE;
              done  <= 1'b1;
            end else if (x == xr) begin
              x <= xl;
              y <= y + 1'b1;
            end else if (mode_r == RECT_OUTLINE && inner_row && x == xl) begin
              x <= xr;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_rectangle_gen.sv
// Self-checking bench for draw_rectangle_gen: directed corner cases plus
// randomized rectangles, compared against a set-based pixel model.
module tb_draw_rectangle_gen;
  import draw_pkg::*;

  localparam int CORDW = 10;
  localparam int CMAX  = (1 << CORDW) - 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             oe    = 1'b0;
  rect_mode_t       mode  = RECT_FILL;
  logic [CORDW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [CORDW-1:0] x, y;
  logic             drawing, busy, done;

  int errors = 0;
  int checks = 0;
  int exp_x[$];
  int exp_y[$];

  always #5 clk = ~clk;

  draw_rectangle_gen #(.CORDW(CORDW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .oe      (oe),
    .mode    (mode),
    .x0      (x0),
    .y0      (y0),
    .x1      (x1),
    .y1      (y1),
    .x       (x),
    .y       (y),
    .drawing (drawing),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Pixel set of the rectangle, listed row by row, left to right.
  task automatic build_expected(input int ax0, input int ay0, input int ax1, input int ay1,
                                input bit outline);
    int l, r, t, b;
    l = (ax0 < ax1) ? ax0 : ax1;
    r = (ax0 < ax1) ? ax1 : ax0;
    t = (ay0 < ay1) ? ay0 : ay1;
    b = (ay0 < ay1) ? ay1 : ay0;
    exp_x.delete();
    exp_y.delete();
    for (int row = t; row <= b; row++)
      for (int col = l; col <= r; col++)
        if (!outline || row == t || row == b || col == l || col == r) begin
          exp_x.push_back(col);
          exp_y.push_back(row);
        end
  endtask

  task automatic scramble_inputs();
    x0   = CORDW'($urandom);
    y0   = CORDW'($urandom);
    x1   = CORDW'($urandom);
    y1   = CORDW'($urandom);
    mode = rect_mode_t'($urandom_range(1));
  endtask

  // Entered just after a rising edge; start is presented in that cycle.
  // Returns just after the rising edge of the done cycle, or after a reset
  // when rst_at names the pixel index at which reset is applied.
  // oe_pct < 0 selects oe high on alternate cycles.
  task automatic run_rect(input int ax0, input int ay0, input int ax1, input int ay1,
                          input bit outline, input int oe_pct, input bit poke, input int rst_at);
    int idx, cyc, n;
    bit oe_now;
    idx = 0;
    cyc = 0;
    build_expected(ax0, ay0, ax1, ay1, outline);
    n = exp_x.size();
    x0    = CORDW'(ax0);
    y0    = CORDW'(ay0);
    x1    = CORDW'(ax1);
    y1    = CORDW'(ay1);
    mode  = outline ? RECT_OUTLINE : RECT_FILL;
    start = 1'b1;
    oe    = 1'($urandom_range(1));
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) scramble_inputs();
    @(negedge clk);
    check("init_busy", busy, 1);
    check("init_drawing", drawing, 0);
    forever begin
      @(posedge clk); #1;
      if (idx == n) begin
        start = 1'b0;
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_drawing", drawing, 0);
        return;
      end
      cyc++;
      if (cyc > 5000) begin
        check("timeout_pixels", idx, n);
        return;
      end
      oe_now = (oe_pct < 0) ? cyc[0] : ($urandom_range(99) < oe_pct);
      oe = oe_now;
      if (poke) begin
        start = 1'($urandom_range(1));
        scramble_inputs();
      end
      @(negedge clk);
      check("draw_busy", busy, 1);
      check("draw_done", done, 0);
      check("drawing", drawing, oe_now);
      check("pix_x", x, exp_x[idx]);
      check("pix_y", y, exp_y[idx]);
      if (oe_now) idx++;
      if (rst_at >= 0 && oe_now && idx == rst_at + 1) begin
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_drawing", drawing, 0);
        check("rst_done", done, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        @(posedge clk); #1;
        check("rst_start_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        return;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_width", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int a, b, c, d, sz;
    #2;
    check("reset_busy", busy, 0);
    check("reset_drawing", drawing, 0);
    check("reset_done", done, 0);
    check("reset_x", x, 0);
    check("reset_y", y, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill, then an outline started in the done cycle of the fill.
    run_rect(2, 3, 4, 5, 1'b0, 100, 1'b0, -1);
    run_rect(13, 12, 10, 10, 1'b1, 100, 1'b0, -1);
    idle_cycle();

    // Alternating oe with start pulsed and inputs changed mid-draw.
    run_rect(0, 0, 2, 0, 1'b0, -1, 1'b1, -1);
    idle_cycle();

    // Single pixel at the top of the coordinate range, both modes.
    run_rect(CMAX, CMAX, CMAX, CMAX, 1'b0, 100, 1'b0, -1);
    idle_cycle();
    run_rect(CMAX, CMAX, CMAX, CMAX, 1'b1, 100, 1'b0, -1);
    idle_cycle();

    // Reset at the 4th pixel, then a complete redraw.
    run_rect(0, 0, 3, 3, 1'b0, 100, 1'b0, 3);
    run_rect(0, 0, 3, 3, 1'b0, 100, 1'b0, -1);
    idle_cycle();

    // Edge-of-range rectangles, single column and single row outlines.
    run_rect(CMAX - 3, CMAX - 2, CMAX, CMAX, 1'b1, 70, 1'b0, -1);
    idle_cycle();
    run_rect(CMAX, CMAX - 3, CMAX - 2, CMAX, 1'b0, 70, 1'b1, -1);
    idle_cycle();
    run_rect(5, 7, 5, 2, 1'b1, 100, 1'b0, -1);
    idle_cycle();
    run_rect(9, 4, 3, 4, 1'b1, 100, 1'b0, -1);
    idle_cycle();

    for (int i = 0; i < 25; i++) begin
      a  = $urandom_range(CMAX);
      b  = $urandom_range(CMAX);
      sz = $urandom_range(11);
      c  = (a + sz > CMAX) ? CMAX : a + sz;
      sz = $urandom_range(11);
      d  = (b + sz > CMAX) ? CMAX : b + sz;
      if ($urandom_range(1) == 1)
        run_rect(c, b, a, d, 1'($urandom_range(1)), $urandom_range(30, 100),
                 1'($urandom_range(1)), -1);
      else
        run_rect(a, d, c, b, 1'($urandom_range(1)), $urandom_range(30, 100),
                 1'($urandom_range(1)), -1);
      if ($urandom_range(1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
